// File: rtl/divider_arbiter_if.sv
// Handshake bundle for divider_arbiter: two requester channels plus the shared divider port.
// slave is the arbiter's view; master is the view of the sources, sinks and the divider.
interface divider_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in0_a, in0_b, in1_a, in1_b;
    logic             in0_a_stb, in0_a_ack, in0_b_stb, in0_b_ack;
    logic             in1_a_stb, in1_a_ack, in1_b_stb, in1_b_ack;
    logic [WIDTH-1:0] out0_z, out1_z;
    logic             out0_z_stb, out0_z_ack, out1_z_stb, out1_z_ack;
    logic [WIDTH-1:0] div_a, div_b, div_z;
    logic             div_a_stb, div_a_ack, div_b_stb, div_b_ack;
    logic             div_z_stb, div_z_ack;

    modport slave (
        input  in0_a, in0_a_stb, in0_b, in0_b_stb,
        input  in1_a, in1_a_stb, in1_b, in1_b_stb,
        output in0_a_ack, in0_b_ack, in1_a_ack, in1_b_ack,
        output out0_z, out0_z_stb, out1_z, out1_z_stb,
        input  out0_z_ack, out1_z_ack,
        output div_a, div_a_stb, div_b, div_b_stb, div_z_ack,
        input  div_a_ack, div_b_ack, div_z, div_z_stb
    );

    modport master (
        output in0_a, in0_a_stb, in0_b, in0_b_stb,
        output in1_a, in1_a_stb, in1_b, in1_b_stb,
        input  in0_a_ack, in0_b_ack, in1_a_ack, in1_b_ack,
        input  out0_z, out0_z_stb, out1_z, out1_z_stb,
        output out0_z_ack, out1_z_ack,
        input  div_a, div_a_stb, div_b, div_b_stb, div_z_ack,
        output div_a_ack, div_b_ack, div_z, div_z_stb
    );
endinterface

// File: rtl/divider_arbiter.sv
// Shares one stb/ack divider between two requester channels, one operation at a time,
// with round-robin priority on ties and every output driven straight from a flop.
module divider_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    divider_arbiter_if.slave bus
);

    localparam logic [2:0] ARB   = 3'd0;
    localparam logic [2:0] GET   = 3'd1;
    localparam logic [2:0] PUT_A = 3'd2;
    localparam logic [2:0] PUT_B = 3'd3;
    localparam logic [2:0] GET_Z = 3'd4;
    localparam logic [2:0] PUT_Z = 3'd5;

    logic [2:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic             prio_q, prio_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             in0_ack_q, in0_ack_d;
    logic             in1_ack_q, in1_ack_d;
    logic             div_a_stb_q, div_a_stb_d;
    logic             div_b_stb_q, div_b_stb_d;
    logic             div_z_ack_q, div_z_ack_d;
    logic             out0_z_stb_q, out0_z_stb_d;
    logic             out1_z_stb_q, out1_z_stb_d;
    logic [WIDTH-1:0] out0_z_q, out0_z_d;
    logic [WIDTH-1:0] out1_z_q, out1_z_d;

    logic req0, req1, grant, owner_z_ack;

    // A channel only counts as requesting once both of its operands are offered.
    assign req0        = bus.in0_a_stb & bus.in0_b_stb;
    assign req1        = bus.in1_a_stb & bus.in1_b_stb;
    assign grant       = (req0 & req1) ? prio_q : req1;
    assign owner_z_ack = owner_q ? bus.out1_z_ack : bus.out0_z_ack;

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a latch.
        state_d      = state_q;
        owner_d      = owner_q;
        prio_d       = prio_q;
        a_d          = a_q;
        b_d          = b_q;
        in0_ack_d    = in0_ack_q;
        in1_ack_d    = in1_ack_q;
        div_a_stb_d  = div_a_stb_q;
        div_b_stb_d  = div_b_stb_q;
        div_z_ack_d  = div_z_ack_q;
        out0_z_stb_d = out0_z_stb_q;
        out1_z_stb_d = out1_z_stb_q;
        out0_z_d     = out0_z_q;
        out1_z_d     = out1_z_q;

        case (state_q)
            ARB: begin
                if (req0 || req1) begin
                    owner_d   = grant;
                    in0_ack_d = ~grant;
                    in1_ack_d = grant;
                    state_d   = GET;
                end
            end
            GET: begin
                // The owner's stb is still high here because it has not yet seen an ack.
                a_d         = owner_q ? bus.in1_a : bus.in0_a;
                b_d         = owner_q ? bus.in1_b : bus.in0_b;
                in0_ack_d   = 1'b0;
                in1_ack_d   = 1'b0;
                div_a_stb_d = 1'b1;
                state_d     = PUT_A;
            end
            PUT_A: begin
                if (bus.div_a_ack) begin
                    div_a_stb_d = 1'b0;
                    div_b_stb_d = 1'b1;
                    state_d     = PUT_B;
                end
            end
            PUT_B: begin
                if (bus.div_b_ack) begin
                    div_b_stb_d = 1'b0;
                    div_z_ack_d = 1'b1;
                    state_d     = GET_Z;
                end
            end
            GET_Z: begin
                if (bus.div_z_stb) begin
                    div_z_ack_d = 1'b0;
                    if (owner_q) begin
                        out1_z_d     = bus.div_z;
                        out1_z_stb_d = 1'b1;
                    end else begin
                        out0_z_d     = bus.div_z;
                        out0_z_stb_d = 1'b1;
                    end
                    state_d = PUT_Z;
                end
            end
            PUT_Z: begin
                if (owner_z_ack) begin
                    out0_z_stb_d = 1'b0;
                    out1_z_stb_d = 1'b0;
                    prio_d       = ~owner_q;
                    state_d      = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: data registers are cleared too, so an abandoned operation leaves no stale value.
            state_q      <= ARB;
            owner_q      <= 1'b0;
            prio_q       <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            in0_ack_q    <= 1'b0;
            in1_ack_q    <= 1'b0;
            div_a_stb_q  <= 1'b0;
            div_b_stb_q  <= 1'b0;
            div_z_ack_q  <= 1'b0;
            out0_z_stb_q <= 1'b0;
            out1_z_stb_q <= 1'b0;
            out0_z_q     <= '0;
            out1_z_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            prio_q       <= prio_d;
            a_q          <= a_d;
            b_q          <= b_d;
            in0_ack_q    <= in0_ack_d;
            in1_ack_q    <= in1_ack_d;
            div_a_stb_q  <= div_a_stb_d;
            div_b_stb_q  <= div_b_stb_d;
            div_z_ack_q  <= div_z_ack_d;
            out0_z_stb_q <= out0_z_stb_d;
            out1_z_stb_q <= out1_z_stb_d;
            out0_z_q     <= out0_z_d;
            out1_z_q     <= out1_z_d;
        end
    end

    // Operand a and b of a channel are always accepted together.
    assign bus.in0_a_ack  = in0_ack_q;
    assign bus.in0_b_ack  = in0_ack_q;
    assign bus.in1_a_ack  = in1_ack_q;
    assign bus.in1_b_ack  = in1_ack_q;
    assign bus.div_a      = a_q;
    assign bus.div_b      = b_q;
    assign bus.div_a_stb  = div_a_stb_q;
    assign bus.div_b_stb  = div_b_stb_q;
    assign bus.div_z_ack  = div_z_ack_q;
    assign bus.out0_z     = out0_z_q;
    assign bus.out1_z     = out1_z_q;
    assign bus.out0_z_stb = out0_z_stb_q;
    assign bus.out1_z_stb = out1_z_stb_q;

endmodule
